// File: rtl/mips_core_pkg.sv
// mips_core_pkg: shared core types, BTB entry layout and 2-bit saturating counter helpers
package mips_core_pkg;

    typedef enum logic {
        NOT_TAKEN = 1'b0,
        TAKEN     = 1'b1
    } BranchOutcome;

    localparam int BTB_INDEX_BITS = 6;
    localparam int BTB_TAG_BITS   = 8;

    typedef struct packed {
        logic                    valid;
        logic [BTB_TAG_BITS-1:0] tag;
        logic                    is_jump;
        logic [1:0]              cnt;
        logic [29:0]             target;
    } btb_entry_t;

    function automatic logic [1:0] sat2_inc(input logic [1:0] c);
        return (c == 2'b11) ? c : c + 2'b01;
    endfunction

    function automatic logic [1:0] sat2_dec(input logic [1:0] c);
        return (c == 2'b00) ? c : c - 2'b01;
    endfunction

endpackage

// File: rtl/branch_target_buffer_stats.sv
// btb_stats: free-running 20-bit lookup and hit counters for the BTB
module btb_stats (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_req_valid,
    input  logic        i_hit,
    output logic [19:0] o_lookups,
    output logic [19:0] o_hits
);

    logic [19:0] lookups_q, lookups_d, hits_q, hits_d;

    // next counts; both wrap modulo 2^20
    always_comb begin
        lookups_d = lookups_q + 20'(i_req_valid);
        hits_d    = hits_q + 20'(i_req_valid & i_hit);
    end

    // counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lookups_q <= '0;
            hits_q    <= '0;
        end else begin
            lookups_q <= lookups_d;
            hits_q    <= hits_d;
        end
    end

    assign o_lookups = lookups_q;
    assign o_hits    = hits_q;

endmodule

// File: rtl/branch_target_buffer.sv
// branch_target_buffer: direct-mapped tagged BTB giving fetch a target and taken hint
module branch_target_buffer
    import mips_core_pkg::*;
#(
    parameter int         INDEX_BITS = BTB_INDEX_BITS,
    parameter int         TAG_BITS   = BTB_TAG_BITS,
    parameter logic [1:0] CNT_INIT   = 2'd1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_req_valid,
    input  logic [31:0] i_req_pc,
    output logic        o_hit,
    output logic        o_taken,
    output logic [31:0] o_target,
    input  logic        i_fb_valid,
    input  logic [31:0] i_fb_pc,
    input  logic        i_fb_is_jump,
    input  logic        i_fb_outcome,
    input  logic [31:0] i_fb_target,
    input  logic        i_flush,
    output logic [19:0] o_lookups,
    output logic [19:0] o_hits
);

    localparam int ENTRIES = 1 << INDEX_BITS;
    localparam int TAG_LO  = INDEX_BITS + 2;
    localparam int TAG_HI  = INDEX_BITS + TAG_BITS + 1;

    logic [ENTRIES-1:0]    valid_q, valid_d;
    logic [TAG_BITS-1:0]   tag_q [ENTRIES];
    logic [TAG_BITS-1:0]   tag_d [ENTRIES];
    logic                  jmp_q [ENTRIES];
    logic                  jmp_d [ENTRIES];
    logic [1:0]            cnt_q [ENTRIES];
    logic [1:0]            cnt_d [ENTRIES];
    logic [29:0]           tgt_q [ENTRIES];
    logic [29:0]           tgt_d [ENTRIES];

    logic [INDEX_BITS-1:0] rq_idx, fb_idx;
    logic [TAG_BITS-1:0]   rq_tag, fb_tag;
    logic                  fb_hit, fb_taken;
    btb_entry_t            rd_e;
    logic                  unused_ok;

    assign rq_idx   = i_req_pc[INDEX_BITS+1:2];
    assign rq_tag   = i_req_pc[TAG_HI:TAG_LO];
    assign fb_idx   = i_fb_pc[INDEX_BITS+1:2];
    assign fb_tag   = i_fb_pc[TAG_HI:TAG_LO];
    assign fb_hit   = valid_q[fb_idx] && (tag_q[fb_idx] == fb_tag);
    assign fb_taken = BranchOutcome'(i_fb_outcome) == TAKEN;

    // zero-latency read of the indexed entry; sees pre-update contents
    always_comb begin
        rd_e = '{valid: valid_q[rq_idx], tag: tag_q[rq_idx], is_jump: jmp_q[rq_idx],
                 cnt: cnt_q[rq_idx], target: tgt_q[rq_idx]};
    end

    assign o_hit    = i_req_valid & rd_e.valid & (rd_e.tag == rq_tag);
    assign o_taken  = o_hit & (rd_e.cnt[1] | rd_e.is_jump);
    assign o_target = o_hit ? {rd_e.target, 2'b00} : '0;

    // training: flush beats feedback, hits adjust the counter, taken misses allocate
    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        jmp_d   = jmp_q;
        cnt_d   = cnt_q;
        tgt_d   = tgt_q;
        if (i_flush) begin
            valid_d = '0;
        end else if (i_fb_valid && fb_hit) begin
            cnt_d[fb_idx] = i_fb_is_jump ? 2'b11
                          : fb_taken     ? sat2_inc(cnt_q[fb_idx]) : sat2_dec(cnt_q[fb_idx]);
            if (fb_taken)
                tgt_d[fb_idx] = i_fb_target[31:2];
        end else if (i_fb_valid && fb_taken) begin
            valid_d[fb_idx] = 1'b1;
            tag_d[fb_idx]   = fb_tag;
            jmp_d[fb_idx]   = i_fb_is_jump;
            cnt_d[fb_idx]   = i_fb_is_jump ? 2'b11 : CNT_INIT + 2'b01;
            tgt_d[fb_idx]   = i_fb_target[31:2];
        end
    end

    // table state; reset empties the table and returns counters to their initial value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i] <= '0;
                jmp_q[i] <= 1'b0;
                cnt_q[i] <= CNT_INIT;
                tgt_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            tag_q   <= tag_d;
            jmp_q   <= jmp_d;
            cnt_q   <= cnt_d;
            tgt_q   <= tgt_d;
        end
    end

    btb_stats u_stats (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_req_valid(i_req_valid),
        .i_hit      (o_hit),
        .o_lookups  (o_lookups),
        .o_hits     (o_hits)
    );

    assign unused_ok = ^{i_req_pc[1:0], i_req_pc[31:TAG_HI+1], i_fb_pc[1:0],
                         i_fb_pc[31:TAG_HI+1], i_fb_target[1:0]};

endmodule

// File: tb/tb_branch_target_buffer.sv
// tb_branch_target_buffer: directed table, reset corner case and randomized model check
module tb_branch_target_buffer;
    import mips_core_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_req_valid = 1'b0;
    logic [31:0] i_req_pc = '0;
    logic        o_hit, o_taken;
    logic [31:0] o_target;
    logic        i_fb_valid = 1'b0;
    logic [31:0] i_fb_pc = '0;
    logic        i_fb_is_jump = 1'b0;
    logic        i_fb_outcome = 1'b0;
    logic [31:0] i_fb_target = '0;
    logic        i_flush = 1'b0;
    logic [19:0] o_lookups, o_hits;

    branch_target_buffer dut (
        .clk(clk), .rst_n(rst_n),
        .i_req_valid(i_req_valid), .i_req_pc(i_req_pc),
        .o_hit(o_hit), .o_taken(o_taken), .o_target(o_target),
        .i_fb_valid(i_fb_valid), .i_fb_pc(i_fb_pc), .i_fb_is_jump(i_fb_is_jump),
        .i_fb_outcome(i_fb_outcome), .i_fb_target(i_fb_target), .i_flush(i_flush),
        .o_lookups(o_lookups), .o_hits(o_hits)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic rv; logic [31:0] rpc;
        logic fv; logic [31:0] fpc; logic fj; logic fo; logic [31:0] ft; logic fl;
        logic eh; logic et; logic [31:0] etg;
    } vec_t;

    int          n_vec = 0;
    int          n_err = 0;
    logic [19:0] exp_lk = '0;
    logic [19:0] exp_hs = '0;

    bit          m_v   [64];
    int          m_tag [64];
    bit          m_j   [64];
    int          m_c   [64];
    logic [31:0] m_t   [64];

    function automatic vec_t mk(bit rv, logic [31:0] rpc, bit fv, logic [31:0] fpc, bit fj,
                                bit fo, logic [31:0] ft, bit fl, bit eh, bit et, logic [31:0] etg);
        return '{rv: rv, rpc: rpc, fv: fv, fpc: fpc, fj: fj, fo: fo, ft: ft, fl: fl,
                 eh: eh, et: et, etg: etg};
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 64; i++) begin
            m_v[i] = 0; m_tag[i] = 0; m_j[i] = 0; m_c[i] = 1; m_t[i] = '0;
        end
    endtask

    task automatic m_look(input bit rv, input logic [31:0] pc, output bit h, output bit t,
                          output logic [31:0] tg);
        int i, g;
        i  = int'(pc / 4) % 64;
        g  = int'(pc / 256) % 256;
        h  = rv && m_v[i] && m_tag[i] == g;
        t  = h && (m_c[i] >= 2 || m_j[i]);
        tg = h ? m_t[i] : 32'h0;
    endtask

    task automatic m_update(input bit fv, input logic [31:0] pc, input bit fj, input bit fo,
                            input logic [31:0] ft, input bit fl);
        int i, g;
        i = int'(pc / 4) % 64;
        g = int'(pc / 256) % 256;
        if (fl) begin
            for (int k = 0; k < 64; k++) m_v[k] = 0;
        end else if (fv && m_v[i] && m_tag[i] == g) begin
            if (fo) begin
                m_c[i] = (m_c[i] + 1 > 3) ? 3 : m_c[i] + 1;
                m_t[i] = ft & ~32'h3;
            end else begin
                m_c[i] = (m_c[i] - 1 < 0) ? 0 : m_c[i] - 1;
            end
            if (fj) m_c[i] = 3;
        end else if (fv && fo) begin
            m_v[i] = 1; m_tag[i] = g; m_j[i] = fj; m_t[i] = ft & ~32'h3;
            m_c[i] = fj ? 3 : 2;
        end
    endtask

    task automatic drive(input vec_t v);
        i_req_valid = v.rv; i_req_pc = v.rpc; i_fb_valid = v.fv; i_fb_pc = v.fpc;
        i_fb_is_jump = v.fj; i_fb_outcome = v.fo; i_fb_target = v.ft; i_flush = v.fl;
    endtask

    task automatic check(input string nm, input bit eh, input bit et, input logic [31:0] etg);
        n_vec++;
        if (o_hit !== eh || o_taken !== et || o_target !== etg ||
            o_lookups !== exp_lk || o_hits !== exp_hs) begin
            n_err++;
            $display("FAIL %s: got hit=%b taken=%b target=%h lookups=%0d hits=%0d, want hit=%b taken=%b target=%h lookups=%0d hits=%0d",
                     nm, o_hit, o_taken, o_target, o_lookups, o_hits, eh, et, etg, exp_lk, exp_hs);
        end
    endtask

    function automatic logic [31:0] rnd_pc();
        return (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 7)) << 2)
             | 32'($urandom_range(0, 3));
    endfunction

    vec_t tbl [20];

    initial begin
        bit          h, t;
        logic [31:0] tg;
        vec_t        v;

        tbl[0]  = mk(1, 32'h400, 0, 32'h0,   0, 0, 32'h0,    0, 0, 0, 32'h0);
        tbl[1]  = mk(1, 32'h400, 1, 32'h400, 0, 1, 32'h480,  0, 0, 0, 32'h0);
        tbl[2]  = mk(1, 32'h400, 1, 32'h400, 0, 0, 32'h0,    0, 1, 1, 32'h480);
        tbl[3]  = mk(1, 32'h400, 1, 32'h400, 0, 0, 32'h0,    0, 1, 0, 32'h480);
        tbl[4]  = mk(1, 32'h400, 1, 32'h400, 0, 0, 32'h0,    0, 1, 0, 32'h480);
        tbl[5]  = mk(1, 32'h400, 0, 32'h0,   0, 0, 32'h0,    0, 1, 0, 32'h480);
        tbl[6]  = mk(1, 32'h500, 1, 32'h500, 0, 1, 32'h900,  0, 0, 0, 32'h0);
        tbl[7]  = mk(1, 32'h400, 0, 32'h0,   0, 0, 32'h0,    0, 0, 0, 32'h0);
        tbl[8]  = mk(1, 32'h500, 0, 32'h0,   0, 0, 32'h0,    0, 1, 1, 32'h900);
        tbl[9]  = mk(1, 32'h500, 1, 32'h500, 0, 1, 32'hA00,  1, 1, 1, 32'h900);
        tbl[10] = mk(1, 32'h500, 0, 32'h0,   0, 0, 32'h0,    0, 0, 0, 32'h0);
        tbl[11] = mk(1, 32'h400, 0, 32'h0,   0, 0, 32'h0,    0, 0, 0, 32'h0);
        tbl[12] = mk(0, 32'h500, 1, 32'h10,  1, 1, 32'h2000, 0, 0, 0, 32'h0);
        tbl[13] = mk(1, 32'h13,  0, 32'h0,   0, 0, 32'h0,    0, 1, 1, 32'h2000);
        tbl[14] = mk(1, 32'h40,  1, 32'h40,  0, 1, 32'h44,   0, 0, 0, 32'h0);
        tbl[15] = mk(1, 32'h40,  1, 32'h41,  0, 1, 32'h48,   0, 1, 1, 32'h44);
        tbl[16] = mk(1, 32'h40,  1, 32'h40,  0, 1, 32'h4C,   0, 1, 1, 32'h48);
        tbl[17] = mk(1, 32'h40,  1, 32'h40,  0, 0, 32'h0,    0, 1, 1, 32'h4C);
        tbl[18] = mk(1, 32'h40,  1, 32'h40,  0, 0, 32'h0,    0, 1, 1, 32'h4C);
        tbl[19] = mk(1, 32'h40,  0, 32'h0,   0, 0, 32'h0,    0, 1, 0, 32'h4C);

        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 20; i++) begin
            drive(tbl[i]);
            #2;
            check($sformatf("table_row%0d", i), tbl[i].eh, tbl[i].et, tbl[i].etg);
            exp_lk += 20'(tbl[i].rv);
            exp_hs += 20'(tbl[i].eh);
            @(negedge clk);
        end

        drive(mk(1, 32'h40, 1, 32'h80, 0, 1, 32'h100, 0, 0, 0, 32'h0));
        #2;
        check("rst_pre", 1, 0, 32'h4C);
        #1 rst_n = 1'b0;
        exp_lk = '0;
        exp_hs = '0;
        m_reset();
        @(posedge clk);
        #1;
        check("rst_hold", 0, 0, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        foreach (tbl[i]) begin
            if (i < 3) begin
                v = mk(1, (i == 0) ? 32'h40 : (i == 1) ? 32'h80 : 32'h500,
                       0, 32'h0, 0, 0, 32'h0, 0, 0, 0, 32'h0);
                drive(v);
                #2;
                check($sformatf("post_rst%0d", i), 0, 0, 32'h0);
                exp_lk += 20'd1;
                @(negedge clk);
            end
        end

        for (int n = 0; n < 600; n++) begin
            v = mk($urandom_range(0, 7) != 0, rnd_pc(), $urandom_range(0, 1) == 1, rnd_pc(),
                   $urandom_range(0, 7) == 0, $urandom_range(0, 2) != 0, $urandom(),
                   $urandom_range(0, 49) == 0, 0, 0, 32'h0);
            drive(v);
            #2;
            m_look(v.rv, v.rpc, h, t, tg);
            check($sformatf("rand%0d", n), h, t, tg);
            exp_lk += 20'(v.rv);
            exp_hs += 20'(h);
            m_update(v.fv, v.fpc, v.fj, v.fo, v.ft, v.fl);
            @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
